// File: rtl/sample_seq_pkg.sv
// rtl/sample_seq_pkg.sv - shared types and helpers for the sample sequencer
package sample_seq_pkg;

    localparam int VOICE_ADDR   = 16;
    localparam int VOICE_FRAC   = 8;
    localparam int VOICE_STEP_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } seq_state_t;

    // Field widths follow the default ADDR/FRAC/STEP_W of the sequencer.
    typedef struct packed {
        logic [VOICE_ADDR-1:0]            start;
        logic [VOICE_ADDR-1:0]            len;
        logic [VOICE_STEP_W-1:0]          step;
        logic [VOICE_ADDR+VOICE_FRAC-1:0] pos;
        logic                             active;
    } voice_t;

    function automatic int mix_width(input int voices, input int width);
        return width + $clog2(voices);
    endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// rtl/sample_sequencer_if.sv - sample ROM address/data bus
interface sample_sequencer_if
    import sample_seq_pkg::*;
#(
    parameter int ADDR  = VOICE_ADDR,
    parameter int WIDTH = 8
);

    logic [ADDR-1:0]  rom_addr;
    logic [WIDTH-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/sample_voice.sv
// rtl/sample_voice.sv - one voice: trigger load, phase advance, end-of-sample detect
module sample_voice
    import sample_seq_pkg::*;
#(
    parameter int ADDR   = VOICE_ADDR,
    parameter int FRAC   = VOICE_FRAC,
    parameter int STEP_W = VOICE_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR-1:0]   ld_start,
    input  logic [ADDR-1:0]   ld_len,
    input  logic [STEP_W-1:0] ld_step,
    input  logic              advance,
    output logic [ADDR-1:0]   fetch_addr,
    output logic              active
);

    localparam int POS_W = ADDR + FRAC;

    voice_t           v_q;
    logic [POS_W-1:0] pos_next;

    assign pos_next   = v_q.pos + POS_W'(v_q.step);
    assign fetch_addr = v_q.start + v_q.pos[POS_W-1:FRAC];
    assign active     = v_q.active;

    // The sample fetched this slot is still mixed even when the voice ends here.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else if (load) begin
            v_q.start  <= ld_start;
            v_q.len    <= ld_len;
            v_q.step   <= ld_step;
            v_q.pos    <= '0;
            v_q.active <= (ld_len != '0);
        end else if (advance && v_q.active) begin
            v_q.pos <= pos_next;
            if (pos_next[POS_W-1:FRAC] >= v_q.len) begin
                v_q.active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - time-shared polyphonic sample ROM playback and mixer
module sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR   = VOICE_ADDR,
    parameter int FRAC   = VOICE_FRAC,
    parameter int STEP_W = VOICE_STEP_W,
    parameter int OUT_W  = mix_width(VOICES, WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic [VOICES-1:0]       trig,
    input  logic [ADDR-1:0]         trig_start,
    input  logic [ADDR-1:0]         trig_len,
    input  logic [STEP_W-1:0]       trig_step,
    sample_sequencer_if.master      rom,
    output logic signed [OUT_W-1:0] mix_out,
    output logic                    mix_valid,
    output logic [VOICES-1:0]       active,
    output logic                    overrun
);

    localparam int SLOT_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    seq_state_t state_q, state_d;

    logic [SLOT_W-1:0]       slot_q, next_slot;
    logic                    live_q, cur_active;
    logic signed [OUT_W-1:0] acc_q, acc_sum, rom_ext;
    logic                    start_frame, fetching, rom_we;
    logic [ADDR-1:0]         addr_next;

    logic [VOICES-1:0]       pend_q;
    logic [ADDR-1:0]         pend_start_q [VOICES];
    logic [ADDR-1:0]         pend_len_q   [VOICES];
    logic [STEP_W-1:0]       pend_step_q  [VOICES];

    logic [VOICES-1:0]       eff_valid, load, advance, voice_active;
    logic [ADDR-1:0]         eff_start [VOICES];
    logic [ADDR-1:0]         eff_len   [VOICES];
    logic [STEP_W-1:0]       eff_step  [VOICES];
    logic [ADDR-1:0]         voice_addr [VOICES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        fetching    = 1'b0;
        rom_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d     = FETCH;
                    start_frame = 1'b1;
                    rom_we      = 1'b1;
                end
            end
            FETCH: begin
                fetching = 1'b1;
                if (slot_q == SLOT_W'(VOICES - 1)) begin
                    state_d = DRAIN;
                end else begin
                    rom_we = 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A trigger arriving in IDLE overrides a pending one for the same voice.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            eff_valid[i] = trig[i] | pend_q[i];
            eff_start[i] = trig[i] ? trig_start : pend_start_q[i];
            eff_len[i]   = trig[i] ? trig_len   : pend_len_q[i];
            eff_step[i]  = trig[i] ? trig_step  : pend_step_q[i];
            load[i]      = (state_q == IDLE) && eff_valid[i];
            advance[i]   = fetching && (slot_q == SLOT_W'(i));
        end
    end

    // Addresses are registered one slot ahead; slot 0 is issued on the tick
    // edge itself, so a voice loaded on that edge needs its fresh start.
    always_comb begin
        addr_next  = '0;
        cur_active = 1'b0;
        next_slot  = start_frame ? '0 : slot_q + SLOT_W'(1);
        for (int i = 0; i < VOICES; i++) begin
            if (SLOT_W'(i) == next_slot) begin
                addr_next = (start_frame && eff_valid[i]) ? eff_start[i] : voice_addr[i];
            end
            if (SLOT_W'(i) == slot_q) begin
                cur_active = voice_active[i];
            end
        end
    end

    assign rom_ext = OUT_W'($signed(rom.rom_data));
    assign acc_sum = acc_q + (live_q ? rom_ext : '0);
    assign active  = voice_active;

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        sample_voice #(
            .ADDR   (ADDR),
            .FRAC   (FRAC),
            .STEP_W (STEP_W)
        ) u_voice (
            .clk        (clk),
            .rst        (rst),
            .load       (load[g]),
            .ld_start   (eff_start[g]),
            .ld_len     (eff_len[g]),
            .ld_step    (eff_step[g]),
            .advance    (advance[g]),
            .fetch_addr (voice_addr[g]),
            .active     (voice_active[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            live_q       <= 1'b0;
            acc_q        <= '0;
            mix_out      <= '0;
            mix_valid    <= 1'b0;
            overrun      <= 1'b0;
            rom.rom_addr <= '0;
            pend_q       <= '0;
            for (int i = 0; i < VOICES; i++) begin
                pend_start_q[i] <= '0;
                pend_len_q[i]   <= '0;
                pend_step_q[i]  <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            overrun   <= sample_tick && (state_q != IDLE);
            live_q    <= fetching && cur_active;

            if (rom_we) begin
                rom.rom_addr <= addr_next;
            end

            if (start_frame) begin
                slot_q <= '0;
                acc_q  <= '0;
            end else if (fetching) begin
                slot_q <= slot_q + SLOT_W'(1);
                acc_q  <= acc_sum;
            end

            if (state_q == DRAIN) begin
                mix_out   <= acc_sum;
                mix_valid <= 1'b1;
            end

            if (state_q == IDLE) begin
                pend_q <= '0;
            end else begin
                for (int i = 0; i < VOICES; i++) begin
                    if (trig[i]) begin
                        pend_q[i]       <= 1'b1;
                        pend_start_q[i] <= trig_start;
                        pend_len_q[i]   <= trig_len;
                        pend_step_q[i]  <= trig_step;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// tb/tb_sample_sequencer.sv - self-checking bench for sample_sequencer
module tb_sample_sequencer;
    import sample_seq_pkg::*;

    localparam int V  = 4;
    localparam int W  = 8;
    localparam int A  = 16;
    localparam int F  = 8;
    localparam int SW = 12;
    localparam int OW = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_tick;
    logic [V-1:0]         trig;
    logic [A-1:0]         trig_start;
    logic [A-1:0]         trig_len;
    logic [SW-1:0]        trig_step;
    logic signed [OW-1:0] mix_out;
    logic                 mix_valid;
    logic [V-1:0]         active;
    logic                 overrun;

    sample_sequencer_if #(.ADDR(A), .WIDTH(W)) rom ();

    sample_sequencer #(
        .VOICES (V),
        .WIDTH  (W),
        .ADDR   (A),
        .FRAC   (F),
        .STEP_W (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .trig        (trig),
        .trig_start  (trig_start),
        .trig_len    (trig_len),
        .trig_step   (trig_step),
        .rom         (rom),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .active      (active),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // ROM contents: word k holds k mod 256, read as signed (128 -> -128).
    always @(posedge clk) rom.rom_data <= rom.rom_addr[7:0];

    int errors = 0;
    int checks = 0;

    int m_start [V];
    int m_len   [V];
    int m_step  [V];
    int m_pos   [V];
    bit m_act   [V];
    bit p_v     [V];
    int p_start [V];
    int p_len   [V];
    int p_step  [V];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rom_val(input int a);
        logic signed [7:0] b;
        b = 8'(a & 255);
        return int'(b);
    endfunction

    function automatic int act_bits();
        int r = 0;
        for (int v = 0; v < V; v++) if (m_act[v]) r |= (1 << v);
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_start[v] = 0; m_len[v] = 0; m_step[v] = 0; m_pos[v] = 0;
            m_act[v] = 0; p_v[v] = 0;
        end
    endtask

    task automatic apply_voice(input int v, input int s, input int l, input int st);
        m_start[v] = s; m_len[v] = l; m_step[v] = st; m_pos[v] = 0;
        m_act[v] = (l != 0);
    endtask

    task automatic apply_pending();
        for (int v = 0; v < V; v++) begin
            if (p_v[v]) apply_voice(v, p_start[v], p_len[v], p_step[v]);
            p_v[v] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_trig(input logic [V-1:0] m, input int s, input int l, input int st);
        trig = m; trig_start = A'(s); trig_len = A'(l); trig_step = SW'(st);
        step();
        trig = '0;
        apply_pending();
        for (int v = 0; v < V; v++) if (m[v]) apply_voice(v, s, l, st);
        check("trig_active", active, act_bits());
    endtask

    // trig_at: 0 = with the tick, 1..V+1 = mid-frame, -1 = none.
    task automatic frame(input int extra_tick, input int trig_at, input logic [V-1:0] tm,
                         input int ts, input int tl, input int tst);
        int exp_mix;
        int addr [V];
        apply_pending();
        if (trig_at == 0) begin
            for (int v = 0; v < V; v++) if (tm[v]) apply_voice(v, ts, tl, tst);
            trig = tm; trig_start = A'(ts); trig_len = A'(tl); trig_step = SW'(tst);
        end
        exp_mix = 0;
        for (int v = 0; v < V; v++) begin
            addr[v] = (m_start[v] + (m_pos[v] >> F)) & 16'hFFFF;
            if (m_act[v]) begin
                exp_mix += rom_val(addr[v]);
                m_pos[v] = (m_pos[v] + m_step[v]) & 24'hFFFFFF;
                if ((m_pos[v] >> F) >= m_len[v]) m_act[v] = 0;
            end
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        trig = '0;
        check("rom_addr_slot0", rom.rom_addr, addr[0]);
        for (int c = 1; c <= V + 1; c++) begin
            if (c == extra_tick) sample_tick = 1'b1;
            if (c == trig_at) begin
                trig = tm; trig_start = A'(ts); trig_len = A'(tl); trig_step = SW'(tst);
                for (int v = 0; v < V; v++) begin
                    if (tm[v]) begin
                        p_v[v] = 1; p_start[v] = ts; p_len[v] = tl; p_step[v] = tst;
                    end
                end
            end
            step();
            sample_tick = 1'b0;
            trig = '0;
            check("rom_addr_slot", rom.rom_addr, addr[(c < V) ? c : V - 1]);
            check("overrun", overrun, (c == extra_tick) ? 1 : 0);
            check("mix_valid_timing", mix_valid, (c == V + 1) ? 1 : 0);
        end
        check("mix_out", mix_out, exp_mix);
        check("frame_active", active, act_bits());
        step();
        check("mix_valid_drop", mix_valid, 0);
        check("mix_out_held", mix_out, exp_mix);
        check("overrun_idle", overrun, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_addr"}, rom.rom_addr, 0);
        check({tag, "_mix_out"}, mix_out, 0);
        check({tag, "_mix_valid"}, mix_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_active"}, active, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int vmask, tat, xt;
        rst = 1'b1; sample_tick = 1'b0; trig = '0;
        trig_start = '0; trig_len = '0; trig_step = '0;
        model_reset();
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Integer step through three words.
        do_trig(4'b0001, 10, 3, 'h100);
        for (int k = 0; k < 4; k++) frame(-1, -1, '0, 0, 0, 0);

        // Half-rate step: each word played twice.
        do_trig(4'b0001, 0, 4, 'h080);
        for (int k = 0; k < 9; k++) frame(-1, -1, '0, 0, 0, 0);

        // All voices held on -128: full negative range without wrap.
        do_trig(4'b1111, 128, 5, 0);
        frame(-1, -1, '0, 0, 0, 0);

        // Mid-frame retrigger of voice 2 takes effect next frame.
        frame(-1, 2, 4'b0100, 20, 2, 'h100);
        frame(-1, -1, '0, 0, 0, 0);

        // Zero length leaves the voice silent.
        do_trig(4'b0001, 50, 0, 'h100);

        // Early tick while fetching.
        frame(3, -1, '0, 0, 0, 0);
        frame(-1, -1, '0, 0, 0, 0);

        // Trigger coinciding with the tick plays in that frame.
        frame(-1, 0, 4'b1000, 7, 2, 'h100);

        // Reset in the middle of FETCH aborts the frame.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_reset_outputs("midrst");
        begin
            int pulses = 0;
            for (int c = 0; c < V + 2; c++) begin
                step();
                if (mix_valid) pulses++;
            end
            check("midrst_no_valid", pulses, 0);
        end
        do_trig(4'b0011, 5, 2, 'h100);
        frame(-1, -1, '0, 0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            vmask = $urandom_range(1, 15);
            if ($urandom_range(0, 3) == 0) begin
                do_trig(V'(vmask), $urandom_range(0, 65535), $urandom_range(0, 5),
                        $urandom_range(0, 'h2FF));
            end else begin
                tat = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, V + 1);
                xt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, V) : -1;
                frame(xt, tat, V'(vmask), $urandom_range(0, 65535), $urandom_range(0, 5),
                      $urandom_range(0, 'h2FF));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Polyphonic playback controller for the single-port, 1-cycle-latency sample ROM (`samples`). Up to VOICES independent voices, each with start address, length and fixed-point pitch step, time-share the ROM: on every audio `sample_tick` the block issues one ROM read per voice, sums the returned signed samples and presents one mixed sample to the DAC/PWM stage. It owns the ROM address bus exclusively.

## Interface
- VOICES, 4: number of voices (≥1).
- WIDTH, 8: ROM sample width (signed).
- ADDR, 16: ROM address width.
- FRAC, 8: fractional bits of the phase accumulator and step.
- STEP_W, 12: step width; integer part is STEP_W-FRAC bits.
- OUT_W, WIDTH+$clog2(VOICES): mixed output width (signed, no overflow possible).

- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse per audio sample period.
- trig  in  VOICES  per-voice (re)start strobe.
- trig_start  in  ADDR  first ROM address of the triggered sample (shared by all trig bits).
- trig_len  in  ADDR  sample length in words.
- trig_step  in  STEP_W  phase increment per tick, unsigned fixed point (1.0 = 1<<FRAC).
- rom_addr  out  ADDR  registered address to `samples.addr`.
- rom_data  in  WIDTH  signed `samples.data`, valid one cycle after rom_addr.
- mix_out  out  OUT_W  signed mixed sample, held between frames.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- active  out  VOICES  voice playing flags.
- overrun  out  1  one-cycle pulse when a tick arrives while not IDLE.

## Operation
- Per voice: active, start, len, step, pos (ADDR+FRAC bits, integer part = offset into sample).
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: sample_tick -> FETCH, slot counter = 0, accumulator = 0.
  - FETCH: rom_addr <= start[slot] + pos[slot] integer part (mod 2^ADDR); slot increments each cycle; after slot VOICES-1 -> DRAIN.
  - DRAIN: one cycle to accept last rom_data -> DONE.
  - DONE: mix_out <= accumulator, mix_valid = 1, -> IDLE.
- Accumulate: on each cycle following a FETCH cycle, acc += active[prev_slot] ? sign-extended rom_data : 0. Inactive voices still consume their slot (fixed frame length).
- Phase advance: in the FETCH cycle of an active voice, pos <= pos + step; if new integer part ≥ len, active <= 0 (last fetched sample still mixed). Step 0 holds the voice on one sample indefinitely.
- Trigger: trig bits plus trig_start/len/step are captured into a pending register in any cycle (later trig overwrites earlier for the same voice; different voices accumulate). Pending triggers apply only in IDLE (the cycle they are seen or first IDLE cycle after DONE): start/len/step loaded, pos = 0, active = (len != 0). Retrigger of an active voice restarts it. Pending apply has priority over a same-cycle sample_tick (applied voices are fetched in that frame).
- sample_tick while not IDLE: dropped, overrun pulses for one cycle.
- rom_addr unchanged outside FETCH.

## Timing
- Reset values: state IDLE, all voice registers 0, active = 0, pending cleared, rom_addr = 0, mix_out = 0, mix_valid = 0, overrun = 0.
- rst mid-frame aborts the frame; no mix_valid is produced.
- Tick sampled at edge T: rom_addr for voice i valid in cycle T+1+i; DRAIN at T+1+VOICES; mix_valid high in cycle T+2+VOICES. Frame = VOICES+2 cycles; minimum tick spacing VOICES+3 cycles.
- Trigger seen in IDLE at edge T affects the frame started by a tick at T or later.
- mix_out changes only together with mix_valid.

## Structure
- Package sample_seq_pkg: state enum (IDLE/FETCH/DRAIN/DONE), voice record typedef (start, len, step, pos, active), helper for OUT_W.
- Sub-module sample_voice: one voice's registers, trigger load, phase advance and end-of-sample detection; instantiated VOICES times. Top holds FSM, slot counter, address mux, accumulator, pending triggers.

## Test plan
- ROM with ram[k]=k (k<128); trig voice0 start=10 len=3 step=0x100; ticks every 8 cycles -> mix_out 10, 11, 12, then 0 with active[0]=0 after the third frame.
- Voice0 start=0 step=0x080 len=4 -> mix_out 0,0,1,1,2,2,3,3, then 0; rom_addr valid at T+1 and mix_valid at T+6 (VOICES=4).
- All 4 voices on ram value -128 (sign test ROM) -> mix_out = -512, no wrap, OUT_W=10.
- Tick 3 cycles after previous tick -> overrun pulse one cycle, no extra mix_valid, next properly spaced tick works.
- Trig voice2 during FETCH -> voice2 unchanged for current frame, plays from pos 0 next frame; trig with len=0 -> active stays 0.
- Assert rst during FETCH -> no mix_valid, all outputs at reset values next cycle, fresh tick produces correct frame.
